// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle MIPS sequencer and its datapath.
// master = controller side (drives strobes), slave = datapath side.
interface multicycle_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;

    logic             iord;
    logic             mem_req;
    logic             mem_write;
    logic             ir_write;
    logic             pc_write;
    logic             pc_en;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_control;
    logic [1:0]       pc_src;
    logic [3:0]       state;
    logic             halted;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output iord, mem_req, mem_write, ir_write, pc_write, pc_en,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_control, pc_src, state, halted, err_code,
               cycle_cnt, instr_cnt
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  iord, mem_req, mem_write, ir_write, pc_write, pc_en,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_control, pc_src, state, halted, err_code,
               cycle_cnt, instr_cnt
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Sequencing FSM for the multicycle MIPS datapath with memory-ready timeout.
// Optional perf counters (cycle_cnt/instr_cnt) are built only when MC_PERF_EN is defined.
module multicycle_ctrl #(
    parameter int unsigned WAIT_LIMIT = 15,
    parameter int unsigned CNT_W      = 32
) (
    input  logic              clk,
    input  logic              clr_n,
    multicycle_ctrl_if.master bus
);

    localparam int unsigned WAIT_W = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_LIMIT);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BEQ    = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11,
        HALT   = 4'd15
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_ILLEGAL = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    err_t              err_q, err_d;
    err_t              halt_cause;

    logic       iord_c, mem_req_c, mem_write_c, ir_write_c, pc_write_c, branch_c;
    logic       reg_dst_c, mem_to_reg_c, reg_write_c, alu_src_a_c;
    logic [1:0] alu_src_b_c, pc_src_c;
    logic [2:0] alu_control_c;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= FETCH;
            wait_q  <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_d        = '0;
        err_d         = err_q;
        halt_cause    = ERR_ILLEGAL;
        iord_c        = 1'b0;
        mem_req_c     = 1'b0;
        mem_write_c   = 1'b0;
        ir_write_c    = 1'b0;
        pc_write_c    = 1'b0;
        branch_c      = 1'b0;
        reg_dst_c     = 1'b0;
        mem_to_reg_c  = 1'b0;
        reg_write_c   = 1'b0;
        alu_src_a_c   = 1'b0;
        alu_src_b_c   = 2'b00;
        alu_control_c = ALU_ADD;
        pc_src_c      = 2'b00;

        // Shared stall/timeout handling for the three memory states; the
        // counter only advances while the state is held, so any exit clears it.
        if ((state_q == FETCH || state_q == MEMRD || state_q == MEMWR) && !bus.mem_ready) begin
            if (wait_q == WAIT_MAX) begin
                state_d    = HALT;
                halt_cause = ERR_TIMEOUT;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end

        case (state_q)
            FETCH: begin
                mem_req_c   = 1'b1;
                alu_src_b_c = 2'b01;
                if (bus.mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = DECODE;
                end
            end
            DECODE: begin
                alu_src_b_c = 2'b11;
                case (bus.opcode)
                    OP_RTYPE:     state_d = EXEC;
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_BEQ:       state_d = BEQ;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default:      state_d = HALT;
                endcase
            end
            MEMADR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                if (bus.opcode == OP_LW) begin
                    state_d = MEMRD;
                end else if (bus.opcode == OP_SW) begin
                    state_d = MEMWR;
                end else begin
                    state_d = HALT;
                end
            end
            MEMRD: begin
                mem_req_c = 1'b1;
                iord_c    = 1'b1;
                if (bus.mem_ready) begin
                    state_d = MEMWB;
                end
            end
            MEMWB: begin
                mem_to_reg_c = 1'b1;
                reg_write_c  = 1'b1;
                state_d      = FETCH;
            end
            MEMWR: begin
                mem_req_c   = 1'b1;
                iord_c      = 1'b1;
                mem_write_c = 1'b1;
                if (bus.mem_ready) begin
                    state_d = FETCH;
                end
            end
            EXEC: begin
                alu_src_a_c = 1'b1;
                state_d     = ALUWB;
                case (bus.funct)
                    FN_ADD:  alu_control_c = ALU_ADD;
                    FN_SUB:  alu_control_c = ALU_SUB;
                    FN_AND:  alu_control_c = ALU_AND;
                    FN_OR:   alu_control_c = ALU_OR;
                    FN_SLT:  alu_control_c = ALU_SLT;
                    default: state_d = HALT;
                endcase
            end
            ALUWB: begin
                reg_dst_c   = 1'b1;
                reg_write_c = 1'b1;
                state_d     = FETCH;
            end
            BEQ: begin
                alu_src_a_c   = 1'b1;
                alu_control_c = ALU_SUB;
                pc_src_c      = 2'b01;
                branch_c      = 1'b1;
                state_d       = FETCH;
            end
            ADDIEX: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                state_d     = ADDIWB;
            end
            ADDIWB: begin
                reg_write_c = 1'b1;
                state_d     = FETCH;
            end
            JUMP: begin
                pc_src_c   = 2'b10;
                pc_write_c = 1'b1;
                state_d    = FETCH;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = HALT;
            end
        endcase

        // Only the first cause is latched; HALT is never left without reset.
        if (state_d == HALT && state_q != HALT && err_q == ERR_NONE) begin
            err_d = halt_cause;
        end
    end

    assign bus.iord        = clr_n & iord_c;
    assign bus.mem_req     = clr_n & mem_req_c;
    assign bus.mem_write   = clr_n & mem_write_c;
    assign bus.ir_write    = clr_n & ir_write_c;
    assign bus.pc_write    = clr_n & pc_write_c;
    assign bus.pc_en       = clr_n & (pc_write_c | (branch_c & bus.zero));
    assign bus.reg_dst     = clr_n & reg_dst_c;
    assign bus.mem_to_reg  = clr_n & mem_to_reg_c;
    assign bus.reg_write   = clr_n & reg_write_c;
    assign bus.alu_src_a   = clr_n & alu_src_a_c;
    assign bus.alu_src_b   = clr_n ? alu_src_b_c : '0;
    assign bus.alu_control = clr_n ? alu_control_c : '0;
    assign bus.pc_src      = clr_n ? pc_src_c : '0;
    assign bus.state       = state_q;
    assign bus.halted      = (state_q == HALT);
    assign bus.err_code    = err_q;

`ifdef MC_PERF_EN
    logic [CNT_W-1:0] cycle_q, instr_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            if (state_q != HALT) begin
                cycle_q <= cycle_q + 1'b1;
            end
            if (state_d == FETCH && state_q != FETCH) begin
                instr_q <= instr_q + 1'b1;
            end
        end
    end

    assign bus.cycle_cnt = cycle_q;
    assign bus.instr_cnt = instr_q;
`else
    assign bus.cycle_cnt = {CNT_W{1'b0}};
    assign bus.instr_cnt = {CNT_W{1'b0}};
`endif

endmodule
